// File: rtl/gpr_dual.sv
// Dual-read, dual-write register file with optional hardwired zero entry,
// same-cycle write forwarding and a registered write-collision flag.
module gpr_dual #(
    parameter int              DW      = 32,
    parameter int              AW      = 5,
    parameter int              ZERO_R0 = 1,
    parameter int              BYPASS  = 1,
    parameter int              GP_IDX  = 28,
    parameter logic [DW-1:0]   GP_INIT = DW'(32'h1800),
    parameter int              SP_IDX  = 29,
    parameter logic [DW-1:0]   SP_INIT = DW'(32'h2ffc)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] A1,
    input  logic [AW-1:0] A2,
    input  logic [AW-1:0] A3,
    input  logic [DW-1:0] WD,
    input  logic          RegWr,
    input  logic [AW-1:0] A4,
    input  logic [DW-1:0] WD2,
    input  logic          RegWr2,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2,
    output logic          wr_conflict
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] GP_A = AW'(GP_IDX);
    localparam logic [AW-1:0] SP_A = AW'(SP_IDX);

    typedef logic [DEPTH-1:0][DW-1:0] image_t;

    // SP is applied last so it wins when both pointers share an index.
    function automatic image_t reset_image();
        image_t img;
        img       = '0;
        img[GP_A] = GP_INIT;
        img[SP_A] = SP_INIT;
        return img;
    endfunction

    localparam image_t IMAGE = reset_image();

    // Entries are held as the difference from the reset image, so an
    // all-zero storage state (reset or power-up) reads back as the image.
    image_t delta;
    logic   conflict_q;
    logic   eff1;
    logic   eff2;
    logic   collide;

    always_comb begin
        eff1    = RegWr  && !reset && !((ZERO_R0 != 0) && (A3 == '0));
        eff2    = RegWr2 && !reset && !((ZERO_R0 != 0) && (A4 == '0));
        collide = eff1 && eff2 && (A3 == A4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            delta      <= '0;
            conflict_q <= 1'b0;
        end else begin
            if (eff1) delta[A3] <= WD ^ IMAGE[A3];
            if (eff2) delta[A4] <= WD2 ^ IMAGE[A4];
            conflict_q <= collide;
        end
    end

    assign wr_conflict = conflict_q;

    // Port 2 forwarding is evaluated last so it wins over port 1.
    always_comb begin
        RD1 = delta[A1] ^ IMAGE[A1];
        RD2 = delta[A2] ^ IMAGE[A2];
        if (BYPASS != 0) begin
            if (eff1 && (A3 == A1)) RD1 = WD;
            if (eff2 && (A4 == A1)) RD1 = WD2;
            if (eff1 && (A3 == A2)) RD2 = WD;
            if (eff2 && (A4 == A2)) RD2 = WD2;
        end
        if ((ZERO_R0 != 0) && (A1 == '0)) RD1 = '0;
        if ((ZERO_R0 != 0) && (A2 == '0)) RD2 = '0;
    end

endmodule

// File: tb/tb_gpr_dual.sv
// Bench for gpr_dual: default instance, a no-bypass instance and a narrow
// ZERO_R0=0 instance, all checked against a queue-based reference model.
module tb_gpr_dual;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic [4:0]  a1 = '0, a2 = '0, a3 = '0, a4 = '0;
    logic [31:0] wd = '0, wd2 = '0;
    logic        we1 = 1'b0, we2 = 1'b0;
    logic [31:0] rd1A, rd2A, rd1B, rd2B;
    logic        confA, confB;

    logic [2:0]  s1 = '0, s2 = '0, s3 = '0, s4 = '0;
    logic [15:0] swd = '0, swd2 = '0;
    logic        swe1 = 1'b0, swe2 = 1'b0;
    logic [15:0] srd1, srd2;
    logic        sconf;

    gpr_dual dutA (
        .clk(clk), .reset(reset), .A1(a1), .A2(a2), .A3(a3), .WD(wd), .RegWr(we1),
        .A4(a4), .WD2(wd2), .RegWr2(we2), .RD1(rd1A), .RD2(rd2A), .wr_conflict(confA)
    );

    gpr_dual #(.BYPASS(0)) dutB (
        .clk(clk), .reset(reset), .A1(a1), .A2(a2), .A3(a3), .WD(wd), .RegWr(we1),
        .A4(a4), .WD2(wd2), .RegWr2(we2), .RD1(rd1B), .RD2(rd2B), .wr_conflict(confB)
    );

    gpr_dual #(.DW(16), .AW(3), .ZERO_R0(0), .GP_IDX(5), .GP_INIT(16'h1111),
               .SP_IDX(5), .SP_INIT(16'h2222)) dutC (
        .clk(clk), .reset(reset), .A1(s1), .A2(s2), .A3(s3), .WD(swd), .RegWr(swe1),
        .A4(s4), .WD2(swd2), .RegWr2(swe2), .RD1(srd1), .RD2(srd2), .wr_conflict(sconf)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic [31:0] memA [32];
    logic [15:0] memC [8];
    wr_t         pendA [$];
    wr_t         pendC [$];
    logic        expConfA = 1'b0;
    logic        expConfC = 1'b0;
    int          tests = 0;
    int          fails = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        foreach (memA[i]) memA[i] = '0;
        foreach (memC[i]) memC[i] = '0;
        memA[28] = 32'h1800;
        memA[29] = 32'h2ffc;
        memC[5]  = 16'h2222;
    endtask

    // Effective writes of the coming edge, listed in port order.
    task automatic gatherWrites();
        wr_t w;
        pendA.delete();
        pendC.delete();
        if (!reset) begin
            if (we1 && a3 != 0) begin w.addr = int'(a3); w.data = wd;  pendA.push_back(w); end
            if (we2 && a4 != 0) begin w.addr = int'(a4); w.data = wd2; pendA.push_back(w); end
            if (swe1) begin w.addr = int'(s3); w.data = 32'(swd);  pendC.push_back(w); end
            if (swe2) begin w.addr = int'(s4); w.data = 32'(swd2); pendC.push_back(w); end
        end
    endtask

    function automatic logic [31:0] readA(input int addr, input bit bypass);
        logic [31:0] v;
        if (addr == 0) return 32'h0;
        v = memA[addr];
        if (bypass) foreach (pendA[i]) if (pendA[i].addr == addr) v = pendA[i].data;
        return v;
    endfunction

    function automatic logic [31:0] readC(input int addr);
        logic [31:0] v;
        v = 32'(memC[addr]);
        foreach (pendC[i]) if (pendC[i].addr == addr) v = pendC[i].data;
        return v;
    endfunction

    task automatic commit();
        if (reset) begin
            resetModel();
            expConfA = 1'b0;
            expConfC = 1'b0;
        end else begin
            foreach (pendA[i]) memA[pendA[i].addr] = pendA[i].data;
            foreach (pendC[i]) memC[pendC[i].addr] = 16'(pendC[i].data);
            expConfA = (pendA.size() == 2) && (pendA[0].addr == pendA[1].addr);
            expConfC = (pendC.size() == 2) && (pendC[0].addr == pendC[1].addr);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic e1, input logic [4:0] ad3,
                                 input logic [31:0] d1, input logic e2, input logic [4:0] ad4,
                                 input logic [31:0] d2, input logic [4:0] ad1, input logic [4:0] ad2);
        @(negedge clk);
        reset = rst; we1 = e1; a3 = ad3; wd = d1; we2 = e2; a4 = ad4; wd2 = d2; a1 = ad1; a2 = ad2;
    endtask

    task automatic applySweep(input logic e1, input logic [2:0] ad3, input logic [15:0] d1,
                              input logic e2, input logic [2:0] ad4, input logic [15:0] d2,
                              input logic [2:0] ad1, input logic [2:0] ad2);
        swe1 = e1; s3 = ad3; swd = d1; swe2 = e2; s4 = ad4; swd2 = d2; s1 = ad1; s2 = ad2;
    endtask

    task automatic runCycle(input string tag);
        gatherWrites();
        #1;
        checkOutput({tag, "/rd1A"}, rd1A, readA(int'(a1), 1'b1));
        checkOutput({tag, "/rd2A"}, rd2A, readA(int'(a2), 1'b1));
        checkOutput({tag, "/rd1B"}, rd1B, readA(int'(a1), 1'b0));
        checkOutput({tag, "/rd2B"}, rd2B, readA(int'(a2), 1'b0));
        checkOutput({tag, "/srd1"}, 32'(srd1), readC(int'(s1)));
        checkOutput({tag, "/srd2"}, 32'(srd2), readC(int'(s2)));
        @(posedge clk);
        commit();
        #1;
        checkOutput({tag, "/confA"}, 32'(confA), 32'(expConfA));
        checkOutput({tag, "/confB"}, 32'(confB), 32'(expConfA));
        checkOutput({tag, "/sconf"}, 32'(sconf), 32'(expConfC));
    endtask

    initial begin
        resetModel();
        a1 = 5'd28; a2 = 5'd29; s1 = 3'd5; s2 = 3'd0;
        #2;
        checkOutput("pwr_gp", rd1A, 32'h1800);
        checkOutput("pwr_sp", rd2A, 32'h2ffc);
        checkOutput("pwr_sweep_sp", 32'(srd1), 32'h2222);
        checkOutput("pwr_conf", 32'(confA), 32'h0);

        applyStimulus(1'b1, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
        runCycle("reset");

        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd28, 5'd29);
        #1;
        checkOutput("r036_gp", rd1A, 32'h1800);
        checkOutput("r036_sp", rd2A, 32'h2ffc);
        checkOutput("r036_sweep_shared_idx", 32'(srd1), 32'h2222);
        checkOutput("r036_conf", 32'(confA), 32'h0);
        runCycle("r036");
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd3);
        #1;
        checkOutput("r036_zero5", rd1A, 32'h0);
        checkOutput("r036_write_in_reset_ignored", rd2A, 32'h0);
        runCycle("r036b");

        applyStimulus(1'b0, 1'b1, 5'd9, 32'hdeadbeef, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        #1;
        checkOutput("r037_bypass", rd1A, 32'hdeadbeef);
        checkOutput("r037_nobypass_old", rd1B, 32'h0);
        runCycle("r037");
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd28);
        #1;
        checkOutput("r037_nobypass_new", rd1B, 32'hdeadbeef);
        runCycle("r037b");

        applyStimulus(1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 5'd7, 5'd9);
        #1;
        checkOutput("r038_fwd_port2", rd1A, 32'h2);
        runCycle("r038");
        checkOutput("r038_conf_set", 32'(confA), 32'h1);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        #1;
        checkOutput("r038_stored", rd1A, 32'h2);
        checkOutput("r038_stored_B", rd1B, 32'h2);
        runCycle("r038b");
        checkOutput("r038_conf_clear", 32'(confA), 32'h0);

        applyStimulus(1'b0, 1'b1, 5'd0, 32'hffffffff, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        #1;
        checkOutput("r039_same", rd1A, 32'h0);
        runCycle("r039");
        checkOutput("r039_conf", 32'(confA), 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd7);
        #1;
        checkOutput("r039_after", rd1A, 32'h0);
        runCycle("r039b");

        applyStimulus(1'b0, 1'b1, 5'd12, 32'h0c0c, 1'b1, 5'd13, 32'h0d0d, 5'd12, 5'd13);
        runCycle("distinct");
        checkOutput("distinct_conf", 32'(confA), 32'h0);

        applyStimulus(1'b1, 1'b1, 5'd29, 32'h5, 1'b1, 5'd29, 32'h6, 5'd29, 5'd12);
        #1;
        checkOutput("r040_no_bypass_in_reset", rd1A, 32'h2ffc);
        runCycle("r040");
        checkOutput("r040_conf", 32'(confA), 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd29, 5'd9);
        #1;
        checkOutput("r040_sp", rd1A, 32'h2ffc);
        checkOutput("r040_cleared", rd2A, 32'h0);
        runCycle("r040b");

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
            applySweep(1'b1, 3'(i), 16'(16'ha500 + i), 1'b0, 3'd0, 16'h0, 3'(i), 3'(i + 1));
            runCycle("r041_wr");
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
            applySweep(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i));
            #1;
            checkOutput("r041_readback", 32'(srd1), 32'(16'ha500 + i));
            runCycle("r041_rd");
        end

        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7)),
                          $urandom, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7)),
                          $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)));
            applySweep(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            runCycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
